// File: rtl/spi_deserializer.sv
// Serial-to-parallel word assembler for the SPI slave datapath.
// Completed words go out through a valid/ready handshake; a word that finds the output still occupied is dropped and flagged.
module spi_deserializer #(
  parameter int WIDTH     = 10,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_W     = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_start,
  input  logic             en,
  input  logic             serial_in,
  input  logic             out_ready,
  output logic [WIDTH-1:0] parallel_out,
  output logic             out_valid,
  output logic             EOC,
  output logic             overrun,
  output logic [CNT_W-1:0] bit_cnt
);

  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] word_nxt;
  logic             shift;
  logic             done;

  assign shift = en && !frame_start;
  assign done  = shift && (bit_cnt == CNT_W'(WIDTH - 1));

  // word_nxt already contains the bit being sampled, so a completing word is built on the same edge.
  generate
    if (MSB_FIRST) begin : g_msb
      assign word_nxt = {shreg[WIDTH-2:0], serial_in};
    end else begin : g_lsb
      always_comb begin
        word_nxt          = shreg;
        word_nxt[bit_cnt] = serial_in;
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg        <= '0;
      bit_cnt      <= '0;
      parallel_out <= '0;
      out_valid    <= 1'b0;
      EOC          <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      EOC <= done;

      if (frame_start || done) begin
        shreg   <= '0;
        bit_cnt <= '0;
      end else if (en) begin
        shreg   <= word_nxt;
        bit_cnt <= bit_cnt + CNT_W'(1);
      end

      // A same-cycle accept frees the slot, so the new word may replace the outgoing one.
      if (done) begin
        if (!out_valid || out_ready) begin
          parallel_out <= word_nxt;
          out_valid    <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      if (frame_start) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_deserializer.sv
// Randomized and directed bench for spi_deserializer (MSB-first and LSB-first instances side by side),
// scoreboarded against a bit-queue reference model.
module tb_spi_deserializer;
  localparam int W = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_start = 1'b0, en = 1'b0, serial_in = 1'b0, out_ready = 1'b0;
  logic [W-1:0] po_m, po_l;
  logic v_m, v_l, e_m, e_l, o_m, o_l;
  logic [3:0] bc_m, bc_l;

  always #5 clk = ~clk;

  spi_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .en(en), .serial_in(serial_in),
    .out_ready(out_ready), .parallel_out(po_m), .out_valid(v_m), .EOC(e_m), .overrun(o_m), .bit_cnt(bc_m));

  spi_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .en(en), .serial_in(serial_in),
    .out_ready(out_ready), .parallel_out(po_l), .out_valid(v_l), .EOC(e_l), .overrun(o_l), .bit_cnt(bc_l));

  typedef struct {
    logic [W-1:0] pm, pl;
    logic v, e, o;
    logic [3:0] bc;
  } rec_t;

  typedef struct {
    logic [W-1:0] pm, pl;
  } word_t;

  rec_t  st_q[$];
  word_t acc_q[$];
  int total = 0;
  int bad = 0;

  // reference model state
  bit          bits[$];
  logic [W-1:0] mpm = '0, mpl = '0;
  bit mv = 0, mo = 0, me = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    bits.delete();
    mpm = '0; mpl = '0; mv = 0; mo = 0; me = 0;
    acc_q.delete();
  endtask

  // One clock cycle: drive inputs, advance model, queue the expected post-edge state.
  task automatic cyc(input bit fs, input bit e, input bit si, input bit rdy);
    bit comp, acc;
    rec_t r;
    word_t w;
    frame_start = fs; en = e; serial_in = si; out_ready = rdy;
    acc  = mv && rdy;
    comp = e && !fs && (bits.size() == W - 1);
    me   = comp;
    if (fs) bits.delete();
    else if (e) bits.push_back(si);
    if (comp) begin
      w.pm = '0; w.pl = '0;
      foreach (bits[i]) begin
        w.pm[W-1-i] = bits[i];
        w.pl[i]     = bits[i];
      end
      bits.delete();
      if (!mv || rdy) begin
        mpm = w.pm; mpl = w.pl; mv = 1;
        acc_q.push_back(w);
      end else begin
        mo = 1;
      end
    end else if (acc) begin
      mv = 0;
    end
    if (fs) mo = 0;
    r.pm = mpm; r.pl = mpl; r.v = mv; r.e = me; r.o = mo; r.bc = 4'(bits.size());
    @(posedge clk);
    st_q.push_back(r);
    #1;
  endtask

  task automatic send_word(input logic [W-1:0] wd, input bit rdy);
    logic [W-1:0] t;
    t = wd;
    for (int i = W - 1; i >= 0; i--) cyc(0, 1, t[i], rdy);
  endtask

  // Monitor: per-cycle state scoreboard plus accepted-word scoreboard.
  always @(negedge clk) begin
    if (rst_n && v_m && out_ready) begin
      if (acc_q.size() == 0) chk("accept_unexpected", 32'(v_m), 32'd0);
      else begin
        word_t w;
        w = acc_q.pop_front();
        chk("accept_word_m", 32'(po_m), 32'(w.pm));
        chk("accept_word_l", 32'(po_l), 32'(w.pl));
      end
    end
    if (st_q.size() > 0) begin
      rec_t r;
      r = st_q.pop_front();
      chk("parallel_out_m", 32'(po_m), 32'(r.pm));
      chk("parallel_out_l", 32'(po_l), 32'(r.pl));
      chk("out_valid", {30'd0, v_m, v_l}, {30'd0, r.v, r.v});
      chk("eoc", {30'd0, e_m, e_l}, {30'd0, r.e, r.e});
      chk("overrun", {30'd0, o_m, o_l}, {30'd0, r.o, r.o});
      chk("bit_cnt", {24'd0, bc_m, bc_l}, {24'd0, r.bc, r.bc});
    end
  end

  task automatic chk_zero(input string name);
    chk(name, {po_m, po_l, v_m, v_l, e_m, e_l, o_m, o_l, bc_m, bc_l}, '0);
  endtask

  initial begin
    int n;
    model_reset();
    #12;
    chk_zero("reset_state");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // basic word, consumer ready
    send_word(10'h2CE, 1);
    #1;
    chk("word_2ce_m", 32'(po_m), 32'h2CE);
    chk("word_1cd_l", 32'(po_l), 32'h1CD);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);

    // consumer stalled: second word dropped, overrun set
    send_word(10'h2CE, 0);
    send_word(10'h155, 0);
    #1;
    chk("stall_hold_m", 32'(po_m), 32'h2CE);
    chk("stall_overrun", 32'(o_m), 32'd1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);

    // partial word discarded, including the bit sampled with frame_start
    for (int i = 0; i < 5; i++) cyc(0, 1, 1'(i & 1), 1);
    cyc(1, 1, 0, 1);
    send_word(10'h3FF, 1);
    #1;
    chk("frame_discard_m", 32'(po_m), 32'h3FF);
    cyc(0, 0, 0, 1);

    // pending word accepted in the same cycle a new word completes
    send_word(10'h0F0, 0);
    for (int i = W - 1; i >= 1; i--) cyc(0, 1, 1'b0, 0);
    cyc(0, 1, 1'b1, 1);
    #1;
    chk("replace_word_m", 32'(po_m), 32'h001);
    chk("replace_valid", 32'(v_m), 32'd1);
    chk("replace_overrun", 32'(o_m), 32'd0);
    cyc(0, 0, 0, 1);

    // asynchronous reset between edges after 7 bits
    for (int i = 0; i < 7; i++) cyc(0, 1, 1'b1, 0);
    en = 1'b0;
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk_zero("async_reset");
    model_reset();
    #1 rst_n = 1'b1;
    send_word(10'h2AA, 1);
    #1;
    chk("after_reset_m", 32'(po_m), 32'h2AA);
    cyc(0, 0, 0, 1);

    // randomized traffic
    for (int i = 0; i < 600; i++)
      cyc($urandom_range(15) == 0, $urandom_range(3) != 0, 1'($urandom), 1'($urandom));

    n = 0;
    while (st_q.size() > 0 && n < 10) begin
      @(posedge clk); n++;
    end
    if (st_q.size() > 0) chk("drain_timeout", 32'(st_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
